// File: rtl/mio_responder.sv
// mio_responder: MIO bus responder with word RAM, LED register, switch port and cycle counter.
// Defining MIO_BUS_ERR_EN adds bus_err, flagging unmapped accesses and writes to the switch port.
module mio_responder #(
  parameter int          RAM_AW  = 10,
  parameter int          RAM_LAT = 2,
  parameter logic [31:0] IO_BASE = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_mio,
  input  logic        mem_rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mio_ready,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
`ifdef MIO_BUS_ERR_EN
  ,
  output logic        bus_err
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [2:0] T_RAM = 3'd0, T_LED = 3'd1, T_SW = 3'd2, T_CNT = 3'd3, T_UNM = 3'd4;
  state_t state_q, state_d;
  logic [31:0] addr_q, wdata_q, cnt_q, cnt_d, rdata_q, rdata_d, sel_addr, offs, rd_val;
  logic [15:0] led_q, led_d;
  logic [3:0] wait_q, wait_d;
  logic [2:0] tgt;
  logic rw_q, sel_rw, we, unused;
  logic [RAM_AW-1:0] idx;
  logic [31:0] mem [2**RAM_AW];
  assign unused = ^addr[1:0];
  // In IDLE the live request is decoded so IO accesses can answer in the next cycle.
  assign sel_addr = state_q == IDLE ? addr : addr_q;
  assign sel_rw = state_q == IDLE ? mem_rw : rw_q;
  assign offs = sel_addr - IO_BASE;
  assign idx = sel_addr[RAM_AW+1:2];
  assign tgt = ~|sel_addr[31:RAM_AW+2] ? T_RAM :
               offs[31:2] == 30'd0 ? T_LED :
               offs[31:2] == 30'd1 ? T_SW :
               offs[31:2] == 30'd2 ? T_CNT : T_UNM;
  assign rd_val = tgt == T_RAM ? mem[idx] :
                  tgt == T_LED ? {16'b0, led_q} :
                  tgt == T_SW ? {16'b0, sw_in} :
                  tgt == T_CNT ? cnt_q : 32'b0;
  assign we = state_q == RESP && rw_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !cpu_mio ? IDLE : (tgt == T_RAM && RAM_LAT > 0) ? WAIT : RESP;
      WAIT: state_d = wait_q == 4'd0 ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mio_ready = state_q == RESP;
    rdata = rdata_q;
`ifdef MIO_BUS_ERR_EN
    bus_err = state_q == RESP && (tgt == T_UNM || (rw_q && tgt == T_SW));
`endif
  end
  always_comb begin
    wait_d = state_q == IDLE ? 4'(RAM_LAT - 1) : wait_q - 4'd1;
    rdata_d = (state_d == RESP && state_q != RESP && !sel_rw) ? rd_val : 32'b0;
    led_d = (we && tgt == T_LED) ? wdata_q[15:0] : led_q;
    cnt_d = (we && tgt == T_CNT) ? wdata_q : cnt_q + 32'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      rw_q <= 1'b0;
      wait_q <= '0;
      rdata_q <= '0;
      led_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state_q == IDLE && cpu_mio) begin
        addr_q <= addr;
        wdata_q <= wdata;
        rw_q <= mem_rw;
      end
      wait_q <= wait_d;
      rdata_q <= rdata_d;
      led_q <= led_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (rst_n && we && tgt == T_RAM) mem[idx] <= wdata_q;
  assign led_out = led_q;
endmodule

// File: tb/tb_mio_responder.sv
// tb_mio_responder: directed checks of latency, address map, counter wrap and reset abandonment.
module tb_mio_responder;
  localparam logic [31:0] IOB = 32'hF000_0000;
  logic clk = 0, rst_n = 0, cpu_mio = 0, mem_rw = 0, mio_ready, bus_err_w;
  logic [31:0] addr = 0, wdata = 0, rdata, rd;
  logic [15:0] sw_in = 0, led_out;
  logic be;
  int lat, checks = 0, errors = 0;
  mio_responder dut (
    .clk(clk), .rst_n(rst_n), .cpu_mio(cpu_mio), .mem_rw(mem_rw), .addr(addr), .wdata(wdata),
    .mio_ready(mio_ready), .rdata(rdata), .sw_in(sw_in), .led_out(led_out)
`ifdef MIO_BUS_ERR_EN
    , .bus_err(bus_err_w)
`endif
  );
`ifndef MIO_BUS_ERR_EN
  assign bus_err_w = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic rw, input logic [31:0] a, input logic [31:0] d,
                      output int l, output logic [31:0] r, output logic b);
    cpu_mio = 1; mem_rw = rw; addr = a; wdata = d; l = 0; r = 'x; b = 0;
    for (int n = 1; n <= 40 && l == 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (mio_ready) begin l = n; r = rdata; b = bus_err_w; end
    end
    cpu_mio = 0;
    @(posedge clk); #1;
  endtask
  initial begin
    #12;
    chk("rst_ready", {31'b0, mio_ready}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_led", {16'b0, led_out}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    xact(1, 32'h10, 32'hDEAD_BEEF, lat, rd, be);
    chk("ram_wr_lat", lat, 3);
    xact(0, 32'h10, 0, lat, rd, be);
    chk("ram_rd_lat", lat, 3);
    chk("ram_rd_data", rd, 32'hDEAD_BEEF);
    xact(1, IOB, 32'h1234_ABCD, lat, rd, be);
    chk("led_wr_lat", lat, 1);
    chk("led_out", {16'b0, led_out}, 32'h0000_ABCD);
    xact(0, IOB, 0, lat, rd, be);
    chk("led_rd", rd, 32'h0000_ABCD);
    sw_in = 16'h00F0;
    xact(0, IOB + 4, 0, lat, rd, be);
    chk("sw_lat", lat, 1);
    chk("sw_rd", rd, 32'h0000_00F0);
    xact(1, IOB + 4, 32'h5555_5555, lat, rd, be);
    chk("sw_wr_be", {31'b0, be}, `ifdef MIO_BUS_ERR_EN 1 `else 0 `endif);
    chk("sw_wr_led", {16'b0, led_out}, 32'h0000_ABCD);
    xact(1, IOB + 8, 32'hFFFF_FFFE, lat, rd, be);
    chk("cnt_wr_lat", lat, 1);
    @(posedge clk); @(posedge clk); #1;
    xact(0, IOB + 8, 0, lat, rd, be);
    chk("cnt_wrap", rd, 32'h0000_0000);
    xact(0, IOB + 8, 0, lat, rd, be);
    chk("cnt_run", rd, 32'h0000_0002);
    xact(0, 32'h8000_0000, 0, lat, rd, be);
    chk("unm_lat", lat, 1);
    chk("unm_rd", rd, 0);
    chk("unm_be", {31'b0, be}, `ifdef MIO_BUS_ERR_EN 1 `else 0 `endif);
    @(negedge clk);
    chk("unm_be_after", {31'b0, bus_err_w}, 0);
    @(posedge clk); #1;
    xact(0, 32'h1000, 0, lat, rd, be);
    chk("ram_edge_lat", lat, 1);
    chk("ram_edge_rd", rd, 0);
    sw_in = 16'h0A5A;
    cpu_mio = 1; mem_rw = 0; addr = IOB + 4;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("b2b_ready%0d", n), {31'b0, mio_ready}, n % 2);
      if (n % 2) chk($sformatf("b2b_data%0d", n), rdata, 32'h0000_0A5A);
      else chk($sformatf("b2b_zero%0d", n), rdata, 0);
      if (n == 5) cpu_mio = 0;
    end
    @(posedge clk); #1;
    xact(1, 32'h20, 32'h1111_2222, lat, rd, be);
    cpu_mio = 1; mem_rw = 1; addr = 32'h20; wdata = 32'h3333_4444;
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("midrst_ready", {31'b0, mio_ready}, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_led", {16'b0, led_out}, 0);
    cpu_mio = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    xact(0, 32'h20, 0, lat, rd, be);
    chk("midrst_ram", rd, 32'h1111_2222);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
